// File: rtl/calc_pkg.sv
// Shared calculator timing definitions: clock rate, default prescale,
// channel index map and the config FSM state type.
package calc_pkg;

    localparam int CLK_HZ           = 100_000_000;
    localparam int BASE_DIV_DEFAULT = 100_000;

    localparam int CH_DISPLAY  = 0;
    localparam int CH_DEBOUNCE = 1;
    localparam int CH_BLINK    = 2;
    localparam int CH_SAMPLE   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/tick_scheduler_if.sv
// Channel configuration port. A write transfers on the clk edge where
// cfg_valid && cfg_ready are both high; the master holds cfg_ch, cfg_period
// and cfg_en stable while cfg_valid is high, and cfg_ready never depends
// combinationally on cfg_valid.
interface tick_scheduler_if #(
    parameter int N_CH = 4,
    parameter int CH_W = 16
) ();
    localparam int CH_IDX_W = $clog2(N_CH);

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_IDX_W-1:0] cfg_ch;
    logic [CH_W-1:0]     cfg_period;
    logic                cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/tick_prescaler.sv
// Base prescaler: free-running 0..BASE_DIV-1 counter with a registered
// one-clk strobe, first high BASE_DIV clks after reset is released.
module tick_prescaler #(
    parameter int BASE_DIV = calc_pkg::BASE_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic base_tick
);
    localparam int              CNT_W = $clog2(BASE_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BASE_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             base_tick_q, base_tick_d;

    // Next count wraps at LAST; the strobe registers the wrap cycle.
    always_comb begin
        count_d     = (count_q == LAST) ? '0 : count_q + 1'b1;
        base_tick_d = (count_q == LAST);
    end

    // Counter and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            base_tick_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            base_tick_q <= base_tick_d;
        end
    end

    assign base_tick = base_tick_q;
endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: each channel emits a one-clk strobe every
// P base ticks. Config writes are serialised by a small FSM so a channel
// is never rewritten in a cycle where it could advance.
module tick_scheduler
    import calc_pkg::*;
#(
    parameter int BASE_DIV = BASE_DIV_DEFAULT,
    parameter int N_CH     = 4,
    parameter int CH_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    tick_scheduler_if.slave  cfg,
    output logic             base_tick,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  ch_active,
    output cfg_state_e       dbg_state
);
    localparam int CH_IDX_W = $clog2(N_CH);

    cfg_state_e          state_q;
    logic                cfg_ready_q;
    logic [CH_IDX_W-1:0] lat_ch_q;
    logic [CH_W-1:0]     lat_period_q;
    logic                lat_en_q;

    logic [CH_W-1:0] period_q [N_CH];
    logic [CH_W-1:0] period_d [N_CH];
    logic [CH_W-1:0] cnt_q    [N_CH];
    logic [CH_W-1:0] cnt_d    [N_CH];
    logic [N_CH-1:0] en_q, en_d;
    logic [N_CH-1:0] tick_q, tick_d;
    logic [N_CH-1:0] active_q, active_d;

    logic apply_now;
    logic lat_ch_ok;

    tick_prescaler #(.BASE_DIV(BASE_DIV)) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .base_tick (base_tick)
    );

    // The write waits out any base_tick cycle; an out-of-range channel
    // index completes the handshake but touches nothing.
    assign apply_now = (state_q == APPLY) && !base_tick;
    assign lat_ch_ok = (int'(lat_ch_q) < N_CH);

    // Config FSM: latch on transfer, then apply on the first quiet cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cfg_ready_q  <= 1'b1;
            lat_ch_q     <= '0;
            lat_period_q <= '0;
            lat_en_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg.cfg_valid && cfg_ready_q) begin
                        lat_ch_q     <= cfg.cfg_ch;
                        lat_period_q <= cfg.cfg_period;
                        lat_en_q     <= cfg.cfg_en;
                        state_q      <= APPLY;
                        cfg_ready_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    if (!base_tick) begin
                        state_q     <= IDLE;
                        cfg_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Per-channel next state: config write, idle hold, or base-tick count.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            period_d[i] = period_q[i];
            en_d[i]     = en_q[i];
            cnt_d[i]    = cnt_q[i];
            tick_d[i]   = 1'b0;
            active_d[i] = en_q[i] && (period_q[i] != '0);
            if (apply_now && lat_ch_ok && (int'(lat_ch_q) == i)) begin
                period_d[i] = lat_period_q;
                en_d[i]     = lat_en_q;
                cnt_d[i]    = '0;
            end else if (!active_d[i]) begin
                cnt_d[i] = '0;
            end else if (base_tick) begin
                if (cnt_q[i] == period_q[i] - 1'b1) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            en_q     <= '0;
            tick_q   <= '0;
            active_q <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            tick_q   <= tick_d;
            active_q <= active_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign tick          = tick_q;
    assign ch_active     = active_q;
    assign dbg_state     = state_q;
endmodule
